// File: rtl/mem_access_master.sv
// mem_access_master: serialises CPU load/store bursts onto the DataMemory interface
// and returns load data on a backpressured response stream.
module mem_access_master #(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int LW = 4
) (
  input  logic          Clock,
  input  logic          Reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [LW-1:0] req_len,
  input  logic          wdat_valid,
  output logic          wdat_ready,
  input  logic [DW-1:0] wdat,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_last,
  output logic          wr_done,
  output logic          busy,
  output logic [AW-1:0] Adresa,
  output logic [DW-1:0] WD,
  output logic          MemWrite,
  output logic          MemRead,
  input  logic [DW-1:0] ReadData
);
  typedef enum logic [2:0] {IDLE, WR_WAIT, WR_BEAT, RD_BEAT, RD_HOLD, DONE} state_t;
  state_t state, state_nx;
  logic [AW-1:0] addr, wr_addr;
  logic [LW-1:0] len, count;
  logic req_hs, wdat_hs, rsp_hs, last;
  assign req_ready  = state == IDLE;
  assign wdat_ready = state == WR_WAIT;
  assign MemWrite   = state == WR_BEAT;
  assign MemRead    = state == RD_BEAT;
  assign wr_done    = state == DONE;
  assign busy       = state != IDLE;
  assign req_hs     = req_valid && req_ready;
  assign wdat_hs    = wdat_valid && wdat_ready;
  assign rsp_hs     = state == RD_HOLD && rsp_valid && rsp_ready;
  assign last       = count == len;
  // Store address is held from the data handshake so it stays put while starved of data
  assign Adresa     = MemRead ? addr : wr_addr;
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req_hs ? (req_write ? WR_WAIT : RD_BEAT) : IDLE;
      WR_WAIT: state_nx = wdat_hs ? WR_BEAT : WR_WAIT;
      WR_BEAT: state_nx = last ? DONE : WR_WAIT;
      RD_BEAT: state_nx = RD_HOLD;
      RD_HOLD: state_nx = rsp_hs ? (rsp_last ? IDLE : RD_BEAT) : RD_HOLD;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      addr      <= '0;
      wr_addr   <= '0;
      len       <= '0;
      count     <= '0;
      WD        <= '0;
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_data  <= '0;
    end else begin
      if (req_hs) begin
        addr  <= req_addr;
        len   <= req_len;
        count <= '0;
      end
      if (wdat_hs) begin
        WD      <= wdat;
        wr_addr <= addr;
      end
      if (state == WR_BEAT || (rsp_hs && !rsp_last)) begin
        addr  <= addr + AW'(1);
        count <= count + LW'(1);
      end
      if (state == RD_BEAT) begin
        rsp_data  <= ReadData;
        rsp_valid <= 1'b1;
        rsp_last  <= last;
      end
      if (rsp_hs) begin
        rsp_valid <= 1'b0;
        rsp_last  <= 1'b0;
      end
    end
endmodule

// File: tb/tb_mem_access_master.sv
// tb_mem_access_master: directed table-driven bench with a behavioural DataMemory.
module tb_mem_access_master;
  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [3:0]  req_len = '0;
  logic        wdat_valid = 1'b0, wdat_ready;
  logic [15:0] wdat = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_last, wr_done, busy;
  logic [15:0] rsp_data, Adresa, WD, ReadData;
  logic        MemWrite, MemRead;
  logic [15:0] mem [65536];
  int checks = 0, errors = 0, nwrites = 0;
  logic mw_prev = 1'b0;

  typedef struct {
    logic            wr;
    logic [15:0]     addr;
    logic [3:0]      len;
    logic [3:0][15:0] d;
    logic [3:0][15:0] a;
    int              sbeat;
    int              scyc;
  } vec_t;
  vec_t vecs[6];

  mem_access_master dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .wr_done(wr_done), .busy(busy),
    .Adresa(Adresa), .WD(WD), .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData)
  );

  always #5 Clock = ~Clock;
  assign ReadData = mem[Adresa];
  always @(posedge Clock) if (MemWrite) mem[Adresa] <= WD;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge Clock) begin
    chk("mw_mr_exclusive", 32'(MemWrite && MemRead), 0);
    chk("mw_not_consecutive", 32'(MemWrite && mw_prev), 0);
    mw_prev = MemWrite;
    if (MemWrite) nwrites++;
  end

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic run_wr(input vec_t v);
    int w0;
    w0 = nwrites;
    chk("wr_req_ready", 32'(req_ready), 1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = v.addr; req_len = v.len;
    tick;
    req_valid = 1'b0;
    chk("wr_busy", 32'(busy), 1);
    for (int i = 0; i <= int'(v.len); i++) begin
      if (i == v.sbeat)
        for (int k = 0; k < v.scyc; k++) begin
          tick;
          chk("stall_memwrite", 32'(MemWrite), 0);
          chk("stall_adresa", 32'(Adresa), 32'(v.a[i-1]));
          chk("stall_wdat_ready", 32'(wdat_ready), 1);
        end
      chk("wdat_ready", 32'(wdat_ready), 1);
      wdat_valid = 1'b1; wdat = v.d[i];
      tick;
      wdat_valid = 1'b0;
      chk("beat_memwrite", 32'(MemWrite), 1);
      chk("beat_adresa", 32'(Adresa), 32'(v.a[i]));
      chk("beat_wd", 32'(WD), 32'(v.d[i]));
      tick;
      chk("beat_memwrite_drop", 32'(MemWrite), 0);
    end
    chk("wr_done_pulse", 32'(wr_done), 1);
    tick;
    chk("wr_done_clear", 32'(wr_done), 0);
    chk("wr_idle", 32'(busy), 0);
    chk("wr_count", 32'(nwrites - w0), 32'(int'(v.len) + 1));
  endtask

  task automatic run_rd(input vec_t v);
    chk("rd_req_ready", 32'(req_ready), 1);
    req_valid = 1'b1; req_write = 1'b0; req_addr = v.addr; req_len = v.len;
    tick;
    req_valid = 1'b0;
    for (int i = 0; i <= int'(v.len); i++) begin
      chk("rd_memread", 32'(MemRead), 1);
      chk("rd_adresa", 32'(Adresa), 32'(v.a[i]));
      tick;
      chk("rsp_valid", 32'(rsp_valid), 1);
      chk("rsp_data", 32'(rsp_data), 32'(v.d[i]));
      chk("rsp_last", 32'(rsp_last), 32'(i == int'(v.len)));
      chk("hold_memread", 32'(MemRead), 0);
      if (i == v.sbeat)
        for (int k = 0; k < v.scyc; k++) begin
          tick;
          chk("bp_valid", 32'(rsp_valid), 1);
          chk("bp_data", 32'(rsp_data), 32'(v.d[i]));
          chk("bp_last", 32'(rsp_last), 32'(i == int'(v.len)));
          chk("bp_memread", 32'(MemRead), 0);
        end
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      chk("rsp_valid_drop", 32'(rsp_valid), 0);
    end
    chk("rd_idle", 32'(busy), 0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 16'h000A, 4'd0, {48'h0, 16'h1234}, {48'h0, 16'h000A}, 0, 0};
    vecs[1] = '{1'b0, 16'h000A, 4'd0, {48'h0, 16'h1234}, {48'h0, 16'h000A}, 0, 0};
    vecs[2] = '{1'b1, 16'hFFFE, 4'd2, {16'h0, 16'hA003, 16'hA002, 16'hA001},
                {16'h0, 16'h0000, 16'hFFFF, 16'hFFFE}, 0, 0};
    vecs[3] = '{1'b0, 16'hFFFE, 4'd2, {16'h0, 16'hA003, 16'hA002, 16'hA001},
                {16'h0, 16'h0000, 16'hFFFF, 16'hFFFE}, 0, 0};
    vecs[4] = '{1'b1, 16'h0100, 4'd3, {16'h4444, 16'h3333, 16'h2222, 16'h1111},
                {16'h0103, 16'h0102, 16'h0101, 16'h0100}, 2, 5};
    vecs[5] = '{1'b0, 16'h0100, 4'd3, {16'h4444, 16'h3333, 16'h2222, 16'h1111},
                {16'h0103, 16'h0102, 16'h0101, 16'h0100}, 1, 4};
    repeat (2) tick;
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_wdat_ready", 32'(wdat_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_en", 32'({MemWrite, MemRead}), 0);
    chk("rst_adresa_wd", 32'({Adresa, WD}), 0);
    #4 Reset_n = 1'b1;
    tick;
    for (int n = 0; n < 6; n++)
      if (vecs[n].wr) run_wr(vecs[n]);
      else run_rd(vecs[n]);
    // Request raised during a store burst must wait until the FSM returns to IDLE
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0020; req_len = 4'd0;
    tick;
    req_write = 1'b0; req_addr = 16'h000A;
    chk("busy_req_ready0", 32'(req_ready), 0);
    tick;
    chk("busy_req_ready1", 32'(req_ready), 0);
    wdat_valid = 1'b1; wdat = 16'hBEEF;
    tick;
    wdat_valid = 1'b0;
    chk("busy_req_ready2", 32'(req_ready), 0);
    chk("busy_write_adr", 32'(Adresa), 32'h0020);
    tick;
    chk("busy_req_ready3", 32'(req_ready), 0);
    chk("busy_wr_done", 32'(wr_done), 1);
    tick;
    chk("busy_idle_ready", 32'(req_ready), 1);
    tick;
    req_valid = 1'b0;
    chk("busy_late_memread", 32'(MemRead), 1);
    chk("busy_late_adresa", 32'(Adresa), 32'h000A);
    tick;
    chk("busy_late_data", 32'(rsp_data), 32'h1234);
    chk("busy_late_last", 32'(rsp_last), 1);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("busy_late_idle", 32'(busy), 0);
    // Asynchronous reset while a load response is being held
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0100; req_len = 4'd3;
    tick;
    req_valid = 1'b0;
    tick;
    chk("arst_pre_valid", 32'(rsp_valid), 1);
    #4 Reset_n = 1'b0;
    #1;
    chk("arst_rsp_valid", 32'(rsp_valid), 0);
    chk("arst_rsp_data", 32'(rsp_data), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_req_ready", 32'(req_ready), 1);
    chk("arst_mem_en", 32'({MemWrite, MemRead}), 0);
    chk("arst_adresa_wd", 32'({Adresa, WD}), 0);
    repeat (2) tick;
    #3 Reset_n = 1'b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("post_rst_valid", 32'(rsp_valid), 0);
      chk("post_rst_memread", 32'(MemRead), 0);
    end
    rsp_ready = 1'b0;
    run_rd(vecs[1]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
